// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the RV32I fetch stage: FSM states, fault codes,
// the default NOP word and the ROM range helper.
package instruction_fetch_unit_pkg;

    typedef enum logic [2:0] {
        S_ISSUE = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_HALT  = 3'd4
    } fetch_state_e;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_RANGE    = 2'd2,
        FAULT_TIMEOUT  = 2'd3
    } fault_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // A byte PC is outside the ROM when any bit above the word-address field is set.
    function automatic logic pc_out_of_range(input logic [31:0] pc, input int unsigned addr_w);
        return (pc >> (addr_w + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_watchdog.sv
// Cycle counter guarding cache fills; expired pulses on the cycle the count
// would reach TIMEOUT while enabled.
module instruction_fetch_unit_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction cache, hands {pc, instr}
// to decode and latches a sticky fault on bad PCs or a hung cache.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [31:0]       RESET_PC = 32'h0000_0000,
    parameter logic [DATA_W-1:0] NOP      = DATA_W'(NOP_INSTR),
    parameter int unsigned       TIMEOUT  = 64
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    output logic [ADDR_W-1:0] ic_addr,
    input  logic [DATA_W-1:0] ic_instr,
    input  logic              ic_ready,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [31:0]       if_pc,
    output logic              fault,
    output logic [1:0]        fault_code
);

    fetch_state_e      state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [ADDR_W-1:0] ic_addr_q, ic_addr_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] if_instr_q, if_instr_d;
    logic [31:0]       if_pc_q, if_pc_d;
    logic              fault_q, fault_d;
    logic [1:0]        fault_code_q, fault_code_d;

    logic              fault_hit;
    logic [1:0]        fault_hit_code;
    logic [31:0]       pc_inc;
    logic              wd_clear, wd_en, wd_expired;

    assign pc_inc = pc_q + 32'd4;
    assign wd_en  = (state_q == S_WAIT) || (state_q == S_DRAIN);

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ic_addr_d      = ic_addr_q;
        if_valid_d     = if_valid_q;
        if_instr_d     = if_instr_q;
        if_pc_d        = if_pc_q;
        fault_d        = fault_q;
        fault_code_d   = fault_code_q;
        fault_hit      = 1'b0;
        fault_hit_code = FAULT_NONE;

        if (state_q != S_HALT) begin
            if (redirect_valid) begin
                if (redirect_pc[1:0] != 2'b00) begin
                    fault_hit      = 1'b1;
                    fault_hit_code = FAULT_MISALIGN;
                end else if (pc_out_of_range(redirect_pc, ADDR_W)) begin
                    fault_hit      = 1'b1;
                    fault_hit_code = FAULT_RANGE;
                end else begin
                    pc_d       = redirect_pc;
                    if_valid_d = 1'b0;
                    // A fill already in flight must be drained unless it completes now.
                    if ((state_q == S_WAIT || state_q == S_DRAIN) && !ic_ready) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end else begin
                case (state_q)
                    S_ISSUE: state_d = S_WAIT;
                    S_WAIT: begin
                        if (ic_ready) begin
                            if_instr_d = ic_instr;
                            if_pc_d    = pc_q;
                            if_valid_d = 1'b1;
                            state_d    = S_HOLD;
                        end else if (wd_expired) begin
                            fault_hit      = 1'b1;
                            fault_hit_code = FAULT_TIMEOUT;
                        end
                    end
                    S_HOLD: begin
                        if (if_valid_q && id_ready) begin
                            if_valid_d = 1'b0;
                            if (pc_out_of_range(pc_inc, ADDR_W)) begin
                                fault_hit      = 1'b1;
                                fault_hit_code = FAULT_RANGE;
                            end else begin
                                pc_d    = pc_inc;
                                state_d = S_ISSUE;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (ic_ready) begin
                            state_d = S_ISSUE;
                        end else if (wd_expired) begin
                            fault_hit      = 1'b1;
                            fault_hit_code = FAULT_TIMEOUT;
                        end
                    end
                    default: state_d = S_HALT;
                endcase
            end

            if (fault_hit) begin
                state_d      = S_HALT;
                if_valid_d   = 1'b0;
                fault_d      = 1'b1;
                fault_code_d = fault_hit_code;
            end
        end

        // The cache address moves only when a new fetch is about to be issued.
        if (state_d == S_ISSUE) begin
            ic_addr_d = pc_d[ADDR_W+1:2];
        end
    end

    assign wd_clear = (state_d != S_WAIT) && (state_d != S_DRAIN);

    instruction_fetch_unit_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (iCLK),
        .rst_n  (iRST_n),
        .clear  (wd_clear),
        .enable (wd_en),
        .expired(wd_expired)
    );

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q      <= S_ISSUE;
            pc_q         <= RESET_PC;
            ic_addr_q    <= RESET_PC[ADDR_W+1:2];
            if_valid_q   <= 1'b0;
            if_instr_q   <= NOP;
            if_pc_q      <= RESET_PC;
            fault_q      <= 1'b0;
            fault_code_q <= FAULT_NONE;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ic_addr_q    <= ic_addr_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign ic_addr    = ic_addr_q;
    assign if_valid   = if_valid_q;
    assign if_instr   = if_instr_q;
    assign if_pc      = if_pc_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: behavioural cache model, transfer
// scoreboard, a redirect vector table and hand-written multi-cycle sequences.
module tb_instruction_fetch_unit;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 64;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] ic_addr;
    logic [31:0]       ic_instr;
    logic              ic_ready;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              id_ready;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [31:0]       if_pc;
    logic              fault;
    logic [1:0]        fault_code;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } xfer_t;
    xfer_t exp_q[$];

    typedef struct {
        logic [31:0] pc;
        bit          xfer;
        logic [1:0]  code;
        logic [7:0]  addr;
    } vec_t;
    vec_t vecs[8];

    // Cache model state
    int lat  = 3;
    bit hang = 0;
    int c_cnt;

    instruction_fetch_unit #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (32),
        .RESET_PC(32'h0000_0000),
        .NOP     (32'h0000_0013),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .iCLK          (clk),
        .iRST_n        (rst_n),
        .ic_addr       (ic_addr),
        .ic_instr      (ic_instr),
        .ic_ready      (ic_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_ready      (id_ready),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .fault         (fault),
        .fault_code    (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_f(input logic [7:0] a);
        return {8'hC3, a, ~a, 8'h13};
    endfunction

    assign ic_instr = rom_f(ic_addr);

    // Free-running cache: ready pulses for one cycle after `lat` idle cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_cnt    <= 0;
            ic_ready <= 1'b0;
        end else if (hang) begin
            c_cnt    <= 0;
            ic_ready <= 1'b0;
        end else if (ic_ready) begin
            c_cnt    <= 0;
            ic_ready <= 1'b0;
        end else if (c_cnt + 1 >= lat) begin
            ic_ready <= 1'b1;
        end else begin
            c_cnt <= c_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every decode handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && if_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got pc 0x%0h instr 0x%0h, want none", if_pc, if_instr);
            end else begin
                xfer_t e;
                e = exp_q.pop_front();
                chk("xfer_pc", if_pc, e.pc);
                chk("xfer_instr", if_instr, e.instr);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_push(input logic [31:0] pc);
        xfer_t e;
        e.pc    = pc;
        e.instr = rom_f(pc[9:2]);
        exp_q.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
        chk({tag, "_if_instr"}, if_instr, 32'h0000_0013);
        chk({tag, "_if_pc"}, if_pc, 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_fault_code"}, 32'(fault_code), 32'd0);
        chk({tag, "_ic_addr"}, 32'(ic_addr), 32'd0);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        id_ready       = 1'b0;
        exp_q.delete();
        step(2);
        check_reset("rst");
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!if_valid && n < budget) begin
            step(1);
            n++;
        end
        chk(name, 32'(if_valid), 32'd1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        id_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        id_ready       = 1'b0;

        vecs[0] = '{pc: 32'h0000_0040, xfer: 1'b1, code: 2'd0, addr: 8'h00};
        vecs[1] = '{pc: 32'h0000_0042, xfer: 1'b0, code: 2'd1, addr: 8'h00};
        vecs[2] = '{pc: 32'h0000_03FC, xfer: 1'b1, code: 2'd2, addr: 8'hFF};
        vecs[3] = '{pc: 32'h0000_0400, xfer: 1'b0, code: 2'd2, addr: 8'h00};
        vecs[4] = '{pc: 32'h8000_0000, xfer: 1'b0, code: 2'd2, addr: 8'h00};
        vecs[5] = '{pc: 32'h0000_0001, xfer: 1'b0, code: 2'd1, addr: 8'h00};
        vecs[6] = '{pc: 32'h0000_0000, xfer: 1'b1, code: 2'd0, addr: 8'h00};
        vecs[7] = '{pc: 32'h0000_0100, xfer: 1'b1, code: 2'd0, addr: 8'h00};

        // T1: sequential fetch from reset
        lat  = 3;
        hang = 0;
        do_reset();
        exp_push(32'd0);
        exp_push(32'd4);
        exp_push(32'd8);
        exp_push(32'd12);
        id_ready = 1'b1;
        wait_valid("t1_first_valid", 20);
        step(1);
        chk("t1_next_addr", 32'(ic_addr), 32'd1);
        chk("t1_valid_drop", 32'(if_valid), 32'd0);
        wait_drain("t1_drain", 100);
        chk("t1_addr_after", 32'(ic_addr), 32'd4);

        // T2: decode stalls, held outputs must not move
        do_reset();
        wait_valid("t2_valid", 20);
        chk("t2_pc", if_pc, 32'd0);
        chk("t2_instr", if_instr, rom_f(8'd0));
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t2_hold_valid", 32'(if_valid), 32'd1);
            chk("t2_hold_pc", if_pc, 32'd0);
            chk("t2_hold_instr", if_instr, rom_f(8'd0));
            chk("t2_hold_addr", 32'(ic_addr), 32'd0);
        end
        exp_push(32'd0);
        id_ready = 1'b1;
        wait_drain("t2_drain", 10);

        // T3: redirect while a fill is outstanding
        lat = 10;
        do_reset();
        id_ready = 1'b1;
        step(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        exp_push(32'h0000_0040);
        step(1);
        redirect_valid = 1'b0;
        wait_valid("t3_valid", 60);
        chk("t3_addr", 32'(ic_addr), 32'h10);
        chk("t3_pc", if_pc, 32'h40);
        wait_drain("t3_drain", 10);

        // Redirect table: targets, range/alignment faults, sticky first fault
        lat = 2;
        for (int v = 0; v < 8; v++) begin
            do_reset();
            step(6);
            redirect_valid = 1'b1;
            redirect_pc    = vecs[v].pc;
            if (vecs[v].xfer) exp_push(vecs[v].pc);
            step(1);
            redirect_valid = 1'b0;
            id_ready       = 1'b1;
            if (vecs[v].xfer) wait_drain("tbl_drain", 40);
            else step(4);
            step(3);
            chk("tbl_fault", 32'(fault), 32'(vecs[v].code != 2'd0));
            chk("tbl_code", 32'(fault_code), 32'(vecs[v].code));
            if (vecs[v].code != 2'd0) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0000_0401;
                id_ready       = 1'b1;
                step(1);
                redirect_valid = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    step(1);
                    chk("halt_valid", 32'(if_valid), 32'd0);
                    chk("halt_code", 32'(fault_code), 32'(vecs[v].code));
                    chk("halt_addr", 32'(ic_addr), 32'(vecs[v].addr));
                end
                id_ready = 1'b0;
            end
        end

        // T6: hung cache times out, then reset in the middle of a fill
        hang = 1;
        do_reset();
        id_ready = 1'b1;
        step(TIMEOUT - 10);
        chk("t6_no_fault_yet", 32'(fault), 32'd0);
        for (int n = 0; n < 30 && !fault; n++) step(1);
        chk("t6_fault", 32'(fault), 32'd1);
        chk("t6_code", 32'(fault_code), 32'd3);
        chk("t6_valid", 32'(if_valid), 32'd0);

        hang = 0;
        lat  = 3;
        do_reset();
        step(2);
        rst_n = 1'b0;
        #2;
        check_reset("t6_async");
        step(1);
        rst_n = 1'b1;
        exp_push(32'd0);
        exp_push(32'd4);
        id_ready = 1'b1;
        wait_drain("t6_resume", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
